// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
//   state_t        : sequencer states (IDLE -> ACCESS -> RESP)
//   DEPTH          : default number of memory words
//   RW_READ/WRITE  : encoding of the per-requester rw bit
//   onehot2()      : grant index -> 2-bit one-hot
package mem_arb_pkg;

  localparam int   DEPTH    = 128;
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way winner select.
// Config macro: MEM_ARB_RR_EN -- when defined, round-robin using ptr
// (ptr names the preferred requester); otherwise fixed priority with
// requester 0 always winning and no ptr port.
// Ports:
//   req_valid  in  2  request valid per requester
//   ptr        in  1  preferred requester (round-robin build only)
//   grant_oh   out 2  one-hot winner, zero when nobody requests
//   grant_idx  out 1  winner index (meaningful only when grant_oh != 0)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_valid,
`ifdef MEM_ARB_RR_EN
  input  logic       ptr,
`endif
  output logic [1:0] grant_oh,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    grant_oh  = 2'b00;
`ifdef MEM_ARB_RR_EN
    if (req_valid[ptr]) begin
      grant_idx = ptr;
      grant_oh  = onehot2(ptr);
    end else if (req_valid[~ptr]) begin
      grant_idx = ~ptr;
      grant_oh  = onehot2(~ptr);
    end
`else
    if (req_valid[0]) begin
      grant_idx = 1'b0;
      grant_oh  = 2'b01;
    end else if (req_valid[1]) begin
      grant_idx = 1'b1;
      grant_oh  = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of a word-addressed memory
// with combinational read and level-sensitive write (RW=1).
// One transaction at a time: IDLE (handshake) -> ACCESS (memory driven
// for exactly one cycle) -> RESP (one-cycle rsp_valid pulse).
// Config macro: MEM_ARB_RR_EN -- round-robin arbitration when defined,
// fixed priority (requester 0 wins) when undefined.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready[1:0]  per-requester handshake (ready one-hot or 0)
//   req_rw[1:0]               1=write, 0=read
//   req_addr0/1, req_wdata0/1 request address and write data
//   rsp_valid[1:0]            response pulse to the granted requester
//   rsp_rdata, rsp_err        read data / out-of-range flag
//   mem_address, mem_data_in, mem_RW, mem_data_out   memory interface
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = mem_arb_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_rw,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_RW,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t state;
  logic   lat_grant;
  logic   lat_rw;
  logic   lat_oor;

  logic [1:0]        pick_oh;
  logic              pick_idx;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;
  logic              accept;

`ifdef MEM_ARB_RR_EN
  logic ptr;
`endif

  mem_arb_pick u_pick (
    .req_valid (req_valid),
`ifdef MEM_ARB_RR_EN
    .ptr       (ptr),
`endif
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx)
  );

  // Ready is offered only in IDLE; held low while reset is asserted so
  // no handshake appears to complete on a reset edge.
  assign req_ready    = (state == IDLE && !rst) ? pick_oh : 2'b00;
  assign accept       = |(req_valid & req_ready);
  assign sel_rw       = req_rw[pick_idx];
  assign sel_addr     = pick_idx ? req_addr1  : req_addr0;
  assign sel_wdata    = pick_idx ? req_wdata1 : req_wdata0;
  assign sel_in_range = sel_addr < ADDR_W'(DEPTH);

  // mem_address/mem_data_in are loaded at the accept edge and then held,
  // so the memory sees the request during ACCESS and stable values after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_grant   <= 1'b0;
      lat_rw      <= RW_READ;
      lat_oor     <= 1'b0;
      rsp_valid   <= 2'b00;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_RW      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      ptr         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_grant   <= pick_idx;
            lat_rw      <= sel_rw;
            lat_oor     <= !sel_in_range;
            mem_address <= sel_addr;
            mem_data_in <= sel_wdata;
            mem_RW      <= (sel_rw == RW_WRITE) && sel_in_range;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_RW    <= 1'b0;
          rsp_rdata <= (lat_rw == RW_READ && !lat_oor) ? mem_data_out : '0;
          rsp_valid <= onehot2(lat_grant);
          rsp_err   <= lat_oor;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 2'b00;
          rsp_err   <= 1'b0;
`ifdef MEM_ARB_RR_EN
          ptr       <= ~lat_grant;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_rw;
  logic [31:0] req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_RW;
  logic [31:0] mem_data_out;

  int tests = 0;
  int fails = 0;
  int rw_hi = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_RW(mem_RW), .mem_data_out(mem_data_out)
  );

  // Memory model: preloaded with 0xA500_0000 + index on the first edge.
  logic [31:0] mem [0:127];
  bit loaded = 1'b0;
  assign mem_data_out = mem[mem_address[6:0]];
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hA500_0000 + i;
      loaded <= 1'b1;
    end else if (mem_RW) begin
      mem[mem_address[6:0]] <= mem_data_in;
    end
  end
  always @(posedge clk) if (mem_RW === 1'b1) rw_hi++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-requester transaction, started in IDLE at posedge+1.
  task automatic txn(input int r, input logic rw, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input logic exp_wr);
    logic [1:0] oh;
    oh = (r == 0) ? 2'b01 : 2'b10;
    req_valid = oh;
    req_rw[r] = rw;
    if (r == 0) begin req_addr0 = addr; req_wdata0 = wdata; end
    else        begin req_addr1 = addr; req_wdata1 = wdata; end
    #1;
    for (int i = 0; i < 8 && req_ready !== oh; i++) step();
    chk("ready_idle", {30'd0, req_ready}, {30'd0, oh});
    step();                                   // ACCESS
    req_valid = 2'b00;
    chk("access_rw",    {31'd0, mem_RW}, {31'd0, exp_wr});
    chk("access_addr",  mem_address, addr);
    chk("access_ready", {30'd0, req_ready}, 32'd0);
    chk("access_rspv",  {30'd0, rsp_valid}, 32'd0);
    if (exp_wr) chk("access_wdata", mem_data_in, wdata);
    step();                                   // RESP
    chk("resp_valid", {30'd0, rsp_valid}, {30'd0, oh});
    chk("resp_err",   {31'd0, rsp_err}, {31'd0, exp_err});
    chk("resp_rdata", rsp_rdata, exp_rdata);
    chk("resp_ready", {30'd0, req_ready}, 32'd0);
    chk("resp_rw",    {31'd0, mem_RW}, 32'd0);
    step();                                   // back in IDLE
    chk("idle_rspv",  {30'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int rw0;
    logic [1:0] exp_g;
    rst = 1'b1;
    req_valid = 2'b00; req_rw = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    step(); step();

    // Reset state
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rspv",  {30'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err",   {31'd0, rsp_err}, 32'd0);
    chk("rst_addr",  mem_address, 32'd0);
    chk("rst_din",   mem_data_in, 32'd0);
    chk("rst_rw",    {31'd0, mem_RW}, 32'd0);
    rst = 1'b0;

    // Contention: both read continuously; req0 -> addr 1, req1 -> addr 2
    req_rw = 2'b00; req_addr0 = 32'd1; req_addr1 = 32'd2;
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_RR_EN
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      #1;
      chk("cont_ready", {30'd0, req_ready}, {30'd0, exp_g});
      step();
      chk("cont_ready_acc", {30'd0, req_ready}, 32'd0);
      step();
      chk("cont_rspv",  {30'd0, rsp_valid}, {30'd0, exp_g});
      chk("cont_rdata", rsp_rdata, exp_g[0] ? 32'hA500_0001 : 32'hA500_0002);
      step();
    end
    req_valid = 2'b00;
    step();

    // Requester 1: write then read addr 5
    rw0 = rw_hi;
    txn(1, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
    chk("wr_rw_cycles", rw_hi - rw0, 32'd1);
    txn(1, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Out of range write and read at addr 200
    rw0 = rw_hi;
    txn(0, 1'b1, 32'd200, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    txn(0, 1'b0, 32'd200, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("oor_rw_cycles", rw_hi - rw0, 32'd0);
    chk("oor_alias_intact", mem[72], 32'hA500_0048);

    // Preloaded read of addr 0
    txn(0, 1'b0, 32'd0, 32'd0, 32'hA500_0000, 1'b0, 1'b0);

    // Reset during ACCESS of a read
    req_valid = 2'b01; req_rw = 2'b00; req_addr0 = 32'd3;
    #1;
    chk("mid_ready", {30'd0, req_ready}, 32'd1);
    step();                                   // ACCESS
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    chk("mid_rspv",  {30'd0, rsp_valid}, 32'd0);
    chk("mid_addr",  mem_address, 32'd0);
    chk("mid_rdata", rsp_rdata, 32'd0);
    chk("mid_rw",    {31'd0, mem_RW}, 32'd0);
    rst = 1'b0;
    step();
    chk("mid_rspv2", {30'd0, rsp_valid}, 32'd0);
    req_valid = 2'b01;
    #1;
    chk("post_rst_ready", {30'd0, req_ready}, 32'd1);
    txn(0, 1'b0, 32'd3, 32'd0, 32'hA500_0003, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
